// File: rtl/axi_rd_responder_pkg.sv
// Shared types for the tensorcore request interface and the AXI read responder.
package axi_rd_responder_pkg;

  localparam int         AXI_DATA_W     = 256;
  localparam logic [2:0] AXI_MAX_SIZE   = 3'd5;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] BASE;
    logic [1:0]  sel;
    logic        issend;
    logic [5:0]  burst_num;
    logic [2:0]  burst_size;
    logic        request_valid;
  } AXI_out_t;

  typedef struct packed {
    logic                  finish;
    logic [AXI_DATA_W-1:0] data;
    logic [5:0]            burst_id;
    logic                  rvalid;
    logic                  arready;
  } AXI_in_t;

  typedef enum logic [1:0] {IDLE_R, ADDR_R, DATA_R, DONE_R} rsp_state_t;

endpackage

// File: rtl/axi_rd_responder.sv
// Turns one controller read request into a single AXI4 INCR burst and streams
// the returned beats back with their beat index.
//
// state  | meaning
// IDLE_R | waiting for a read request, arready=1
// ADDR_R | AR presented, held until m_arready
// DATA_R | collecting beats, counted against burst_num
// DONE_R | one-cycle completion, finish for zero-length requests
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int              DATA_W = AXI_DATA_W,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  AXI_out_t          req_i,
  output AXI_in_t           rsp_o,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [31:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [ID_W-1:0]   m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              err_o
);

  rsp_state_t        state_q, state_d;
  logic [31:0]       addr_q;
  logic [5:0]        num_q, cnt_q, id_q;
  logic [2:0]        size_q;
  logic              rvalid_q, finish_q, err_q;
  logic [DATA_W-1:0] data_q;

  logic              accept, beat, last_beat, req_err;
  logic [2:0]        size_c;
  logic [31:0]       mask_c, addr_c, end_c;
  logic              unused_sel;

  assign unused_sel = ^req_i.sel;
  assign accept     = (state_q == IDLE_R) && req_i.request_valid && !req_i.issend;
  assign beat       = (state_q == DATA_R) && m_rvalid;
  assign last_beat  = (cnt_q == num_q - 6'd1);
  assign m_arburst  = AXI_BURST_INCR;
  assign m_arid     = AXI_ID;
  assign err_o      = err_q;

  // Errors flagged at accept: oversized beat, misaligned base, 4 KB crossing.
  always_comb begin
    size_c  = (req_i.burst_size > AXI_MAX_SIZE) ? AXI_MAX_SIZE : req_i.burst_size;
    mask_c  = (32'd1 << size_c) - 32'd1;
    addr_c  = req_i.BASE & ~mask_c;
    end_c   = addr_c + ({26'd0, req_i.burst_num} << size_c) - 32'd1;
    req_err = (req_i.burst_size > AXI_MAX_SIZE)
           || ((req_i.BASE & mask_c) != 32'd0)
           || ((req_i.burst_num != 6'd0) && ((end_c ^ addr_c) >= 32'h1000));
  end

  always_comb begin
    state_d        = state_q;
    m_arvalid      = 1'b0;
    m_rready       = 1'b0;
    m_araddr       = '0;
    m_arlen        = '0;
    m_arsize       = '0;
    rsp_o          = '0;
    rsp_o.data     = data_q;
    rsp_o.burst_id = id_q;
    rsp_o.rvalid   = rvalid_q;
    rsp_o.finish   = finish_q;
    case (state_q)
      IDLE_R: begin
        rsp_o.arready = 1'b1;
        if (accept) state_d = (req_i.burst_num == 6'd0) ? DONE_R : ADDR_R;
      end
      ADDR_R: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_q;
        m_arlen   = {2'b00, num_q - 6'd1};
        m_arsize  = size_q;
        if (m_arready) state_d = DATA_R;
      end
      DATA_R: begin
        m_rready = 1'b1;
        if (beat && last_beat) state_d = DONE_R;
      end
      DONE_R: begin
        if (num_q == 6'd0) rsp_o.finish = 1'b1;
        state_d = IDLE_R;
      end
      default: state_d = IDLE_R;
    endcase
  end

  // The burst completes by count; rlast and rresp only feed the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE_R;
      addr_q   <= '0;
      num_q    <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      rvalid_q <= 1'b0;
      finish_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      finish_q <= 1'b0;
      if (accept) begin
        addr_q <= addr_c;
        num_q  <= req_i.burst_num;
        size_q <= size_c;
        cnt_q  <= '0;
        err_q  <= req_err;
      end
      if (beat) begin
        rvalid_q <= 1'b1;
        finish_q <= last_beat;
        data_q   <= m_rdata;
        id_q     <= cnt_q;
        cnt_q    <= cnt_q + 6'd1;
        if ((m_rresp != AXI_RESP_OKAY) || (m_rlast != last_beat)) err_q <= 1'b1;
      end
    end
  end

endmodule
